// File: rtl/dp_issue_stage.sv
// dp_issue_stage: decode/operand stage for ARM data-processing ops.
// Ports: in_valid/in_ready/instr/stall/flags_nzcv in; rf read ports;
//        registered alu_* issue bundle, rd_addr, shift_carry,
//        cond_fail and illegal pulses out.
module dp_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic                  stall,
  input  logic [3:0]            flags_nzcv,
  output logic [3:0]            rn_addr,
  output logic [3:0]            rm_addr,
  output logic [3:0]            rs_addr,
  input  logic [DATA_WIDTH-1:0] rn_data,
  input  logic [DATA_WIDTH-1:0] rm_data,
  input  logic [DATA_WIDTH-1:0] rs_data,
  output logic                  alu_enable,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic                  alu_set_cond,
  output logic                  alu_carry_in,
  output logic [3:0]            rd_addr,
  output logic                  shift_carry,
  output logic                  cond_fail,
  output logic                  illegal
);

  typedef enum logic {IDLE, SHIFT2} state_t;

  state_t      state_q;
  logic        en_q, cf_q, ill_q;
  logic [3:0]  op_q, rd_q;
  logic [31:0] a_q, b_q;
  logic        s_q, cin_q, sc_q;

  // fields held across SHIFT2 for register-shift forms
  logic [3:0]  pop_q, prd_q;
  logic [31:0] prn_q, prm_q;
  logic [7:0]  prs_q;
  logic [1:0]  pty_q;
  logic        ps_q, pc_q;

  logic [23:0] unused_rs;
  assign unused_rs = rs_data[31:8];

  // Generic shift by an 8-bit amount; returns {carry, result}.
  function automatic logic [32:0] sh(
    input logic [31:0] v,
    input logic [7:0]  a,
    input logic [1:0]  t,
    input logic        c
  );
    logic [32:0]        r;
    logic [32:0]        w;
    logic signed [32:0] sv;
    logic [4:0]         a5;
    r  = {c, v};
    a5 = a[4:0];
    if (a != 8'd0) begin
      unique case (t)
        2'd0: begin
          if (a < 8'd32)       r = {1'b0, v} << a;
          else if (a == 8'd32) r = {v[0], 32'd0};
          else                 r = '0;
        end
        2'd1: begin
          w = {v, 1'b0} >> a;
          if (a < 8'd32)       r = {w[0], w[32:1]};
          else if (a == 8'd32) r = {v[31], 32'd0};
          else                 r = '0;
        end
        2'd2: begin
          sv = {v, 1'b0};
          w  = sv >>> a;
          if (a < 8'd32) r = {w[0], w[32:1]};
          else           r = {33{v[31]}};
        end
        2'd3: begin
          if (a5 == 5'd0) begin
            r = {v[31], v};
          end else begin
            r[31:0] = (v >> a5) | (v << (6'd32 - {1'b0, a5}));
            r[32]   = r[31];
          end
        end
      endcase
    end
    return r;
  endfunction

  function automatic logic cond_ok(
    input logic [3:0] cd,
    input logic [3:0] f
  );
    logic n, z, c, v, ok;
    {n, z, c, v} = f;
    unique case (cd)
      4'h0: ok = z;
      4'h1: ok = !z;
      4'h2: ok = c;
      4'h3: ok = !c;
      4'h4: ok = n;
      4'h5: ok = !n;
      4'h6: ok = v;
      4'h7: ok = !v;
      4'h8: ok = c && !z;
      4'h9: ok = !c || z;
      4'hA: ok = (n == v);
      4'hB: ok = (n != v);
      4'hC: ok = !z && (n == v);
      4'hD: ok = z || (n != v);
      4'hE: ok = 1'b1;
      4'hF: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic        accept, reg_form, is_ill, c_in;
  logic [4:0]  rot, sh_amt;
  logic [1:0]  sh_ty;
  logic [31:0] imm_x, imm_b;
  logic [32:0] op2, rsh;

  assign in_ready = (state_q == IDLE) && !stall;
  assign accept   = in_valid && in_ready;
  assign rn_addr  = instr[19:16];
  assign rm_addr  = instr[3:0];
  assign rs_addr  = instr[11:8];

  assign c_in     = flags_nzcv[1];
  assign reg_form = !instr[25] && instr[4];
  // instr[7] with instr[4] and I clear is multiply / extra load-store
  assign is_ill   = (instr[27:26] != 2'b00) || (reg_form && instr[7]);

  assign rot    = {instr[11:8], 1'b0};
  assign imm_x  = {24'd0, instr[7:0]};
  assign imm_b  = (imm_x >> rot) | (imm_x << (6'd32 - {1'b0, rot}));
  assign sh_amt = instr[11:7];
  assign sh_ty  = instr[6:5];

  // Immediate and immediate-shift operand 2; amount 0 encodes
  // LSR/ASR #32 and RRX.
  always_comb begin
    op2 = '0;
    if (instr[25]) begin
      op2 = {(rot != 5'd0) ? imm_b[31] : c_in, imm_b};
    end else if (sh_amt == 5'd0) begin
      unique case (sh_ty)
        2'd0: op2 = {c_in, rm_data};
        2'd1: op2 = sh(rm_data, 8'd32, 2'd1, c_in);
        2'd2: op2 = sh(rm_data, 8'd32, 2'd2, c_in);
        2'd3: op2 = {rm_data[0], c_in, rm_data[31:1]};
      endcase
    end else begin
      op2 = sh(rm_data, {3'd0, sh_amt}, sh_ty, c_in);
    end
  end

  assign rsh = sh(prm_q, prs_q, pty_q, pc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      cf_q    <= 1'b0;
      ill_q   <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= 1'b0;
      cin_q   <= 1'b0;
      sc_q    <= 1'b0;
      pop_q   <= '0;
      prd_q   <= '0;
      prn_q   <= '0;
      prm_q   <= '0;
      prs_q   <= '0;
      pty_q   <= '0;
      ps_q    <= 1'b0;
      pc_q    <= 1'b0;
    end else begin
      en_q  <= 1'b0;
      cf_q  <= 1'b0;
      ill_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_ill) begin
              ill_q <= 1'b1;
            end else if (!cond_ok(instr[31:28], flags_nzcv)) begin
              cf_q <= 1'b1;
            end else if (reg_form) begin
              pop_q   <= instr[24:21];
              ps_q    <= instr[20];
              prd_q   <= instr[15:12];
              pty_q   <= instr[6:5];
              prn_q   <= rn_data;
              prm_q   <= rm_data;
              prs_q   <= rs_data[7:0];
              pc_q    <= c_in;
              state_q <= SHIFT2;
            end else begin
              en_q  <= 1'b1;
              op_q  <= instr[24:21];
              s_q   <= instr[20];
              rd_q  <= instr[15:12];
              a_q   <= rn_data;
              b_q   <= op2[31:0];
              sc_q  <= op2[32];
              cin_q <= c_in;
            end
          end
        end
        SHIFT2: begin
          en_q    <= 1'b1;
          op_q    <= pop_q;
          s_q     <= ps_q;
          rd_q    <= prd_q;
          a_q     <= prn_q;
          b_q     <= rsh[31:0];
          sc_q    <= rsh[32];
          cin_q   <= pc_q;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_enable   = en_q;
  assign cond_fail    = cf_q;
  assign illegal      = ill_q;
  assign alu_op       = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_set_cond = s_q;
  assign alu_carry_in = cin_q;
  assign rd_addr      = rd_q;
  assign shift_carry  = sc_q;

endmodule

// File: tb/tb_dp_issue_stage.sv
// tb_dp_issue_stage: directed + random checks of dp_issue_stage
// against a bit-serial behavioural model.
module tb_dp_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, stall;
  logic [31:0] instr, rn_data, rm_data, rs_data;
  logic [3:0]  flags_nzcv;
  logic [3:0]  rn_addr, rm_addr, rs_addr;
  logic        alu_enable, alu_set_cond, alu_carry_in;
  logic [3:0]  alu_op, rd_addr;
  logic [31:0] alu_a, alu_b;
  logic        shift_carry, cond_fail, illegal;

  dp_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .stall(stall), .flags_nzcv(flags_nzcv),
    .rn_addr(rn_addr), .rm_addr(rm_addr), .rs_addr(rs_addr),
    .rn_data(rn_data), .rm_data(rm_data), .rs_data(rs_data),
    .alu_enable(alu_enable), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_set_cond(alu_set_cond), .alu_carry_in(alu_carry_in),
    .rd_addr(rd_addr), .shift_carry(shift_carry),
    .cond_fail(cond_fail), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // model state
  logic        m_en, m_cf, m_ill, m_s, m_cin, m_sc, m_pend;
  logic [3:0]  m_op, m_rd;
  logic [31:0] m_a, m_b;
  logic        p_s, p_cin, p_sc;
  logic [3:0]  p_op, p_rd;
  logic [31:0] p_a, p_b;

  task automatic m_reset();
    m_en = 0; m_cf = 0; m_ill = 0; m_s = 0; m_cin = 0;
    m_sc = 0; m_pend = 0; m_op = 0; m_rd = 0; m_a = 0; m_b = 0;
  endtask

  function automatic logic cond_pass(input logic [3:0] cd,
                                     input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cd)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // one bit per step; carry is the last bit moved out
  task automatic ref_shift(input logic [31:0] v, input int n,
                           input logic [1:0] t, input logic c,
                           output logic [31:0] r, output logic co);
    r = v;
    co = c;
    for (int i = 0; i < n; i++) begin
      case (t)
        2'd0: begin co = r[31]; r = r << 1; end
        2'd1: begin co = r[0]; r = r >> 1; end
        2'd2: begin co = r[0]; r = {r[31], r[31:1]}; end
        default: begin co = r[0]; r = {r[0], r[31:1]}; end
      endcase
    end
  endtask

  task automatic model_step();
    logic [31:0] r;
    logic        co, c;
    int          n;
    m_en = 0; m_cf = 0; m_ill = 0;
    c = flags_nzcv[1];
    if (m_pend) begin
      m_pend = 0;
      m_en = 1; m_op = p_op; m_a = p_a; m_b = p_b;
      m_s = p_s; m_cin = p_cin; m_rd = p_rd; m_sc = p_sc;
    end else if (in_valid && !stall) begin
      if (instr[27:26] != 0 ||
          (!instr[25] && instr[4] && instr[7])) begin
        m_ill = 1;
      end else if (!cond_pass(instr[31:28], flags_nzcv)) begin
        m_cf = 1;
      end else begin
        if (instr[25]) begin
          ref_shift({24'd0, instr[7:0]}, 2 * int'(instr[11:8]),
                    2'd3, c, r, co);
        end else if (!instr[4]) begin
          n = int'(instr[11:7]);
          if (n == 0 && instr[6:5] == 2'd3) begin
            r = {c, rm_data[31:1]};
            co = rm_data[0];
          end else begin
            if (n == 0 && instr[6:5] != 2'd0) n = 32;
            ref_shift(rm_data, n, instr[6:5], c, r, co);
          end
        end else begin
          ref_shift(rm_data, int'(rs_data[7:0]), instr[6:5],
                    c, r, co);
        end
        if (!instr[25] && instr[4]) begin
          m_pend = 1;
          p_op = instr[24:21]; p_a = rn_data; p_b = r;
          p_s = instr[20]; p_cin = c; p_rd = instr[15:12];
          p_sc = co;
        end else begin
          m_en = 1; m_op = instr[24:21]; m_a = rn_data; m_b = r;
          m_s = instr[20]; m_cin = c; m_rd = instr[15:12];
          m_sc = co;
        end
      end
    end
  endtask

  task automatic chk_outs(string p);
    chk({p, "_en"}, alu_enable, m_en);
    chk({p, "_cf"}, cond_fail, m_cf);
    chk({p, "_ill"}, illegal, m_ill);
    chk({p, "_op"}, alu_op, m_op);
    chk({p, "_a"}, alu_a, m_a);
    chk({p, "_b"}, alu_b, m_b);
    chk({p, "_s"}, alu_set_cond, m_s);
    chk({p, "_cin"}, alu_carry_in, m_cin);
    chk({p, "_rd"}, rd_addr, m_rd);
    chk({p, "_sc"}, shift_carry, m_sc);
  endtask

  // drive one cycle from a negedge, predict, check at next negedge
  task automatic step(input logic v, input logic st,
                      input logic [31:0] ins, input logic [31:0] rn,
                      input logic [31:0] rm, input logic [31:0] rs,
                      input logic [3:0] f);
    in_valid = v; stall = st; instr = ins;
    rn_data = rn; rm_data = rm; rs_data = rs; flags_nzcv = f;
    #1;
    chk("ready", in_ready, !m_pend && !st);
    chk("addr", {rn_addr, rm_addr, rs_addr},
        {ins[19:16], ins[3:0], ins[11:8]});
    model_step();
    @(negedge clk);
    chk_outs("out");
  endtask

  logic [31:0] ri, rs_r;

  initial begin
    rst_n = 0; in_valid = 0; stall = 0; instr = 0;
    rn_data = 0; rm_data = 0; rs_data = 0; flags_nzcv = 0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_en", alu_enable, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_cf_ill", {cond_fail, illegal}, 0);
    rst_n = 1;
    #1 chk("rst_ready", in_ready, 1);
    @(negedge clk);

    step(1, 0, 32'hE3A010FF, 0, 0, 0, 4'h0);
    chk("mov_en", alu_enable, 1);
    chk("mov_op", alu_op, 4'hD);
    chk("mov_b", alu_b, 32'h000000FF);
    chk("mov_rd", rd_addr, 1);

    step(1, 0, 32'hE2801C01, 5, 0, 0, 4'h0);
    chk("add_b", alu_b, 32'h00000100);
    chk("add_a", alu_a, 5);
    chk("add_op", alu_op, 4'h4);

    step(1, 0, 32'hE1A01022, 0, 32'h80000001, 0, 4'h0);
    chk("lsr0_b", alu_b, 0);
    chk("lsr0_c", shift_carry, 1);

    step(1, 0, 32'hE1A01062, 0, 32'h80000001, 0, 4'h0);
    chk("rrx_b", alu_b, 32'h40000000);
    chk("rrx_c", shift_carry, 1);

    step(1, 0, 32'hE1A01312, 0, 32'hFFFFFFFF, 33, 4'h0);
    chk("rs_en1", alu_enable, 0);
    chk("rs_ready", in_ready, 0);
    step(1, 0, 32'hE3A010FF, 0, 0, 0, 4'h0);
    chk("rs_en2", alu_enable, 1);
    chk("rs_b", alu_b, 0);
    chk("rs_c", shift_carry, 0);

    step(1, 0, 32'h03A01001, 0, 0, 0, 4'h0);
    chk("eq_cf", cond_fail, 1);
    chk("eq_en", alu_enable, 0);
    step(1, 0, 32'h03A01001, 0, 0, 0, 4'h4);
    chk("eq_ok", alu_enable, 1);

    step(1, 0, 32'hE5901000, 0, 0, 0, 4'h0);
    chk("ldr_ill", illegal, 1);

    step(1, 1, 32'hE3A010FF, 0, 0, 0, 4'h0);
    chk("stall_none", {alu_enable, cond_fail, illegal}, 0);

    for (int k = 0; k < 600; k++) begin
      ri = $urandom;
      if ($urandom_range(0, 7) != 0) ri[27:26] = 2'b00;
      if ($urandom_range(0, 2) != 0) ri[31:28] = 4'hE;
      rs_r = $urandom;
      case ($urandom_range(0, 3))
        0: rs_r[7:0] = 8'd32;
        1: rs_r[7:0] = 8'($urandom_range(0, 40));
        2: rs_r[7:0] = 8'd0;
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           ri, $urandom, $urandom, rs_r, 4'($urandom));
    end

    step(0, 0, 0, 0, 0, 0, 4'h0);
    step(1, 0, 32'hE1A01312, 7, 32'h12345678, 4, 4'h2);
    rst_n = 0;
    #1;
    m_reset();
    chk_outs("rst2");
    @(negedge clk);
    chk("rst2_en", alu_enable, 0);
    chk("rst2_b", alu_b, 0);
    rst_n = 1;
    step(0, 0, 0, 0, 0, 0, 4'h0);
    chk("rst2_after", alu_enable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_issue_stage.md
# dp_issue_stage

Decode-and-operand stage feeding the data-processing ALU. It accepts one 32-bit ARM data-processing instruction per handshake and evaluates its condition field against the current flags. It builds operand 2 with an immediate rotator or a barrel shifter, then issues a registered one-cycle `alu_enable` pulse together with `alu_op`, `alu_a`, `alu_b`, `alu_set_cond` and `alu_carry_in` to the ALU's inputs.

## Interface
- `DATA_WIDTH`, 32, operand width; only 32 is supported.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `instr` is valid.
- `in_ready` out 1: stage can accept; combinational, `(state==IDLE) && !stall`.
- `instr` in 32: instruction word.
- `stall` in 1: blocks acceptance of new instructions.
- `flags_nzcv` in 4: current N,Z,C,V (bit3 = N).
- `rn_addr`, `rm_addr`, `rs_addr` out 4 each: combinational register-file read addresses = `instr[19:16]`, `instr[3:0]`, `instr[11:8]`.
- `rn_data`, `rm_data`, `rs_data` in 32 each: register-file read data; valid in the same cycle as the address.
- `alu_enable` out 1: one-cycle issue pulse.
- `alu_op` out 4: `instr[24:21]`.
- `alu_a` out 32: Rn value.
- `alu_b` out 32: operand 2.
- `alu_set_cond` out 1: `instr[20]`.
- `alu_carry_in` out 1: C flag sampled at accept.
- `rd_addr` out 4: `instr[15:12]`.
- `shift_carry` out 1: shifter carry-out.
- `cond_fail` out 1: one-cycle pulse; instruction accepted but not executed.
- `illegal` out 1: one-cycle pulse; instruction is not data-processing.

## Operation
- FSM states are IDLE and SHIFT2.
- Accept happens when `in_valid && in_ready`. Latch `instr`, `rn_data`, `rm_data`, `rs_data[7:0]` and `flags_nzcv`.
- Illegal is `instr[27:26] != 2'b00`, or the multiply/extra-load form `I==0 && instr[4]==1 && instr[7]==1`.
  - On an illegal accept, next cycle: `illegal` = 1 and `alu_enable` = 0.
  - The condition check is skipped for an illegal instruction.
- Condition codes follow ARM semantics: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
  - cond `4'hF` is treated as never.
  - On failure, next cycle: `cond_fail` = 1 and `alu_enable` = 0. The stage returns to IDLE even for a register-shift form.
- Immediate (`I==1`):
  - `alu_b = ROR(zero-extend(instr[7:0]), 2*instr[11:8])`.
  - `shift_carry = alu_b[31]` if the rotate is nonzero, else the latched C.
- Immediate shift (`I==0`, `instr[4]==0`): amount = `instr[11:7]`, type = `instr[6:5]`.
  - LSL: amount 0 passes Rm unchanged, and carry = C.
  - LSR: amount 0 means LSR #32, giving 0 with carry = Rm[31].
  - ASR: amount 0 means ASR #32, giving all bits = Rm[31] with carry = Rm[31].
  - ROR: amount 0 means RRX, giving `{C, Rm[31:1]}` with carry = Rm[0].
- Register shift (`I==0`, `instr[4]==1`): amount = latched `rs_data[7:0]`. The shift is computed in SHIFT2 (IDLE to SHIFT2 to IDLE).
  - amount 0: Rm unchanged, carry = C.
  - LSL/LSR by 32: result 0, carry = Rm[0] / Rm[31]. By more than 32: result 0, carry 0.
  - ASR by 32 or more: all bits and carry = Rm[31].
  - ROR: rotate by `amount[4:0]`. If `amount[4:0]==0` and amount != 0: Rm unchanged, carry = Rm[31].
- `alu_a`, `alu_op`, `alu_set_cond`, `alu_carry_in` and `rd_addr` come from the latched values.
- All issue outputs are registered and hold their last value between pulses. Only `alu_enable`, `cond_fail` and `illegal` return to 0.

## Timing
- Reset values:
  - all outputs 0; state IDLE.
  - `in_ready` = `!stall` once `rst_n` deasserts.
- Latency for immediate and immediate-shift forms: accept in cycle N, `alu_enable` = 1 in cycle N+1. Back-to-back issue every cycle is possible.
- Latency for register-shift forms: accept in cycle N, SHIFT2 in N+1, `alu_enable` = 1 in N+2. `in_ready` = 0 during SHIFT2.
- `stall` only blocks acceptance. A SHIFT2 already in progress completes and issues.
- Exactly one of `alu_enable`, `cond_fail`, `illegal` pulses per accepted instruction.
- Reset asserted mid-SHIFT2: the instruction is dropped with no pulse, and all outputs clear immediately.

## Test plan
- Immediate: `instr=0xE3A010FF` (MOV r1,#0xFF) -> next cycle `alu_enable=1`, `alu_op=4'hD`, `alu_b=0x000000FF`, `rd_addr=1`.
- Rotated immediate: `0xE2801C01` (ADD r1,r0,#0x100), `rn_data=5` -> `alu_b=0x00000100`, `alu_a=5`, `alu_op=4'h4`.
- Immediate shifts with `rm_data=0x80000001`, C=0:
  - LSR #0 -> `alu_b=0`, `shift_carry=1`.
  - ROR #0 (RRX) -> `alu_b=0x40000000`, `shift_carry=1`.
- Register shift: `0xE1A01312` (MOV r1,r2,LSL r3) with `rs_data=33`, `rm_data=0xFFFFFFFF` -> `in_ready=0` for one cycle, `alu_enable` at N+2, `alu_b=0`, `shift_carry=0`.
- Condition: `0x03A01001` (MOVEQ) with Z=0 -> `cond_fail=1`, `alu_enable=0`. The same instruction with Z=1 -> `alu_enable=1`.
- Hazards:
  - `0xE5901000` (LDR) -> `illegal=1`.
  - `stall=1` while `in_valid=1` -> no accept, no pulse.
  - `rst_n` low during SHIFT2 -> no `alu_enable`, outputs 0.
